// File: rtl/core_pkg.sv
// Shared definitions for the core instruction bus: field positions, idle word,
// the packed instruction struct and the sequencer state encoding.
package core_pkg;

   localparam int INST_W  = 35;
   localparam int ADDR_BW = 11;

   localparam int B_MODE_OS   = 34;
   localparam int B_ACC       = 33;
   localparam int B_CEN_PMEM  = 32;
   localparam int B_WEN_PMEM  = 31;
   localparam int B_A_PMEM_HI = 30;
   localparam int B_A_PMEM_LO = 20;
   localparam int B_CEN_XMEM  = 19;
   localparam int B_WEN_XMEM  = 18;
   localparam int B_A_XMEM_HI = 17;
   localparam int B_A_XMEM_LO = 7;
   localparam int B_OFIFO_RD  = 6;
   localparam int B_IFIFO_WR  = 5;
   localparam int B_IFIFO_RD  = 4;
   localparam int B_L0_RD     = 3;
   localparam int B_L0_WR     = 2;
   localparam int B_EXECUTE   = 1;
   localparam int B_LOAD      = 0;

   // Both SRAMs deselected and in read mode; everything else quiet.
   localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << B_CEN_PMEM) |
                                             (INST_W'(1) << B_WEN_PMEM) |
                                             (INST_W'(1) << B_CEN_XMEM) |
                                             (INST_W'(1) << B_WEN_XMEM);

   typedef enum logic [2:0] {
      IDLE, WFILL, WLOAD, WFLUSH, XFILL, EXEC, DRAIN, DONE
   } seq_state_t;

   // Field order matches the bit positions above, MSB first.
   typedef struct packed {
      logic               mode_os;
      logic               acc;
      logic               cen_pmem;
      logic               wen_pmem;
      logic [ADDR_BW-1:0] a_pmem;
      logic               cen_xmem;
      logic               wen_xmem;
      logic [ADDR_BW-1:0] a_xmem;
      logic               ofifo_rd;
      logic               ififo_wr;
      logic               ififo_rd;
      logic               l0_rd;
      logic               l0_wr;
      logic               execute;
      logic               load;
   } inst_t;

endpackage

// File: rtl/seq_cnt.sv
// Clearable up-counter with a terminal flag (cnt == lim); one-cycle update,
// no backpressure of its own -- the owner decides when to clear or step.
module seq_cnt #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] lim,
   output logic [W-1:0] cnt,
   output logic         term
);

   assign term = (cnt == lim);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/core_inst_seq.sv
// Weight-stationary tile sequencer driving the core inst bus; inst is registered and changes the cycle after start.
// Drain stalls indefinitely on ofifo_valid; a read and the previous row's pmem write may share a cycle.
module core_inst_seq
   import core_pkg::*;
#(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = ADDR_BW,
   parameter int flush   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode_os,
   input  logic               acc_en,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [addr_bw-1:0] n_act,
   input  logic [addr_bw-1:0] p_base,
   input  logic               ofifo_valid,
   output logic [INST_W-1:0]  inst,
   output logic               busy,
   output logic               done
);

   seq_state_t state, state_nx;
   inst_t      inst_q, inst_d;
   logic       busy_d;
   logic       accept;

   logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q, n_q;
   logic [addr_bw-1:0] w_base_nx;

   logic               ph_clr, ph_term;
   logic [addr_bw-1:0] ph_cnt, ph_lim, ph_nx;

   logic               rd_take, rd_term;
   logic [addr_bw-1:0] rows_read;
   logic               wr_pend, wr_term;
   logic [addr_bw-1:0] rows_written;

   seq_cnt #(.W(addr_bw)) u_phase (
      .clk   (clk),
      .reset (reset),
      .clr   (ph_clr),
      .inc   (1'b1),
      .lim   (ph_lim),
      .cnt   (ph_cnt),
      .term  (ph_term)
   );

   seq_cnt #(.W(addr_bw)) u_rows_read (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .inc   (rd_take),
      .lim   (n_q),
      .cnt   (rows_read),
      .term  (rd_term)
   );

   seq_cnt #(.W(addr_bw)) u_rows_written (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .inc   (wr_pend),
      .lim   (n_q),
      .cnt   (rows_written),
      .term  (wr_term)
   );

   // A row read last cycle is still owed its pmem write exactly when the counts differ.
   assign rd_take = (state == DRAIN) && ofifo_valid && !rd_term;
   assign wr_pend = (state == DRAIN) && (rows_read != rows_written);

   always_comb begin
      ph_lim = '0;
      case (state)
         WFILL:   ph_lim = addr_bw'(row);
         WLOAD:   ph_lim = addr_bw'(col - 1);
         WFLUSH:  ph_lim = addr_bw'(flush - 1);
         XFILL:   ph_lim = n_q;
         EXEC:    ph_lim = n_q - addr_bw'(1);
         default: ph_lim = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = WFILL;
            end
         end
         WFILL:   if (ph_term) state_nx = WLOAD;
         WLOAD:   if (ph_term) state_nx = WFLUSH;
         WFLUSH:  if (ph_term) state_nx = (n_q == '0) ? DONE : XFILL;
         XFILL:   if (ph_term) state_nx = EXEC;
         EXEC:    if (ph_term) state_nx = DRAIN;
         DRAIN:   if (wr_term) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The word registered at this edge describes the cycle in state_nx, so the
   // phase index it uses is the counter's post-edge value.
   assign ph_clr    = (state_nx != state) || (state == IDLE);
   assign ph_nx     = ph_clr ? '0 : ph_cnt + addr_bw'(1);
   assign w_base_nx = accept ? w_base : w_base_q;
   assign busy_d    = (state_nx != IDLE) && (state_nx != DONE);

   always_comb begin
      inst_d = inst_t'(INST_IDLE);
      if (busy_d) begin
         inst_d.mode_os = mode_os;
      end
      case (state_nx)
         WFILL: begin
            if (ph_nx < addr_bw'(row)) begin
               inst_d.cen_xmem = 1'b0;
               inst_d.a_xmem   = w_base_nx + ph_nx;
            end
            inst_d.l0_wr = (ph_nx != '0);
         end
         WLOAD: begin
            inst_d.l0_rd = 1'b1;
            inst_d.load  = 1'b1;
         end
         XFILL: begin
            if (ph_nx != n_q) begin
               inst_d.cen_xmem = 1'b0;
               inst_d.a_xmem   = x_base_q + ph_nx;
            end
            inst_d.l0_wr = (ph_nx != '0);
         end
         EXEC: begin
            inst_d.l0_rd   = 1'b1;
            inst_d.execute = 1'b1;
            inst_d.acc     = acc_en;
         end
         DRAIN: begin
            inst_d.ofifo_rd = rd_take;
            if (wr_pend) begin
               inst_d.cen_pmem = 1'b0;
               inst_d.wen_pmem = 1'b0;
               inst_d.a_pmem   = p_base_q + rows_written;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         inst_q   <= inst_t'(INST_IDLE);
         busy     <= 1'b0;
         done     <= 1'b0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         n_q      <= '0;
      end else begin
         state  <= state_nx;
         inst_q <= inst_d;
         busy   <= busy_d;
         done   <= (state_nx == DONE);
         if (accept) begin
            w_base_q <= w_base;
            x_base_q <= x_base;
            p_base_q <= p_base;
            n_q      <= n_act;
         end
      end
   end

   assign inst = inst_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: every cycle of each tile is compared against
// a word built from the documented field map.
module tb_core_inst_seq;

   localparam int ROW   = 8;
   localparam int COL   = 8;
   localparam int FLUSH = 4;
   localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset, start, mode_os, acc_en, ofifo_valid;
   logic [10:0] w_base, x_base, n_act, p_base;
   logic [34:0] inst;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   core_inst_seq #(.row(ROW), .col(COL), .addr_bw(11), .flush(FLUSH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode_os     (mode_os),
      .acc_en      (acc_en),
      .w_base      (w_base),
      .x_base      (x_base),
      .n_act       (n_act),
      .p_base      (p_base),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      #500000;
      $display("FAIL global_timeout inst=%h busy=%0b", inst, busy);
      $fatal(1, "simulation time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [34:0] mk(input logic mode, input logic acc, input logic pw,
                                      input logic [10:0] ap, input logic xr, input logic [10:0] ax,
                                      input logic ofrd, input logic l0rd, input logic l0wr,
                                      input logic ex, input logic ld);
      logic [34:0] w;
      w       = '0;
      w[34]   = mode;
      w[33]   = acc;
      w[32]   = ~pw;
      w[31]   = ~pw;
      if (pw) w[30:20] = ap;
      w[19]   = ~xr;
      w[18]   = 1'b1;
      if (xr) w[17:7] = ax;
      w[6]    = ofrd;
      w[3]    = l0rd;
      w[2]    = l0wr;
      w[1]    = ex;
      w[0]    = ld;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [34:0] e_inst, input logic e_busy, input logic e_done);
      checks++;
      assert (inst === e_inst) else begin
         errors++;
         $error("FAIL %s inst=%h expected=%h", tag, inst, e_inst);
      end
      checks++;
      assert (busy === e_busy) else begin
         errors++;
         $error("FAIL %s busy=%0b expected=%0b", tag, busy, e_busy);
      end
      checks++;
      assert (done === e_done) else begin
         errors++;
         $error("FAIL %s done=%0b expected=%0b", tag, done, e_done);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Weight fill/load/flush, then activation fill and exec_cycles of EXEC.
   task automatic front(input logic [10:0] w, input logic [10:0] x, input logic [10:0] nn,
                        input logic [10:0] p, input logic mode, input logic acc,
                        input int exec_cycles, input bit poke);
      logic [10:0] a;
      w_base  = w;
      x_base  = x;
      n_act   = nn;
      p_base  = p;
      mode_os = mode;
      acc_en  = acc;
      start   = 1'b1;
      for (int k = 0; k <= ROW; k++) begin
         step();
         start = 1'b0;
         a = w + 11'(k);
         chk("wfill", mk(mode, 1'b0, 1'b0, '0, (k < ROW), a, 1'b0, 1'b0, (k >= 1), 1'b0, 1'b0), 1'b1, 1'b0);
      end
      for (int k = 0; k < COL; k++) begin
         step();
         chk("wload", mk(mode, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
      end
      for (int k = 0; k < FLUSH; k++) begin
         step();
         chk("wflush", mk(mode, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      end
      if (nn != 11'd0) begin
         for (int k = 0; k <= int'(nn); k++) begin
            step();
            a = x + 11'(k);
            chk("xfill", mk(mode, 1'b0, 1'b0, '0, (k < int'(nn)), a, 1'b0, 1'b0, (k >= 1), 1'b0, 1'b0), 1'b1, 1'b0);
         end
         for (int k = 0; k < exec_cycles; k++) begin
            if (poke && k == 1) begin
               start  = 1'b1;
               w_base = 11'h123;
            end
            step();
            start = 1'b0;
            chk("exec", mk(mode, acc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
         end
      end
   endtask

   // OFIFO pulses every `period` cycles (n of them); rd must follow a pulse by
   // one cycle and the pmem write by two, at consecutive wrapped addresses.
   task automatic drain(input logic [10:0] nn, input logic [10:0] p, input logic mode, input int period);
      int          sent, wexp, ph, rd_obs, wr_obs;
      logic        v_cur, v_prev, done_due, seen_done;
      logic [10:0] a;
      sent = 0; wexp = 0; ph = 0; rd_obs = 0; wr_obs = 0;
      v_prev = 1'b0; done_due = 1'b0; seen_done = 1'b0;
      ofifo_valid = 1'b0;
      step();
      chk("drain_entry", mk(mode, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      for (int c = 0; c < 300 && !seen_done; c++) begin
         v_cur = (sent < int'(nn)) && (ph == 0);
         if (v_cur) sent++;
         ph = (ph + 1) % period;
         ofifo_valid = v_cur;
         step();
         if (inst[6]) rd_obs++;
         if (!inst[31]) wr_obs++;
         if (done_due) begin
            chk("drain_done", IDLE_W, 1'b0, 1'b1);
            seen_done = 1'b1;
         end else begin
            a = p + 11'(wexp);
            chk("drain", mk(mode, 1'b0, v_prev, a, 1'b0, '0, v_cur, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
            if (v_prev) begin
               wexp++;
               if (wexp == int'(nn)) done_due = 1'b1;
            end
         end
         v_prev = v_cur;
      end
      ofifo_valid = 1'b0;
      chk_int("drain_finished", int'(seen_done), 1);
      chk_int("ofifo_rd_count", rd_obs, int'(nn));
      chk_int("pmem_wr_count", wr_obs, int'(nn));
      step();
      chk("post_done", IDLE_W, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode_os = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b0;
      w_base = '0; x_base = '0; n_act = '0; p_base = '0;
      step();
      step();
      chk("reset", IDLE_W, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle", IDLE_W, 1'b0, 1'b0);
      end

      // Basic tile, continuous OFIFO availability.
      front(11'd0, 11'd8, 11'd4, 11'h100, 1'b1, 1'b1, 4, 1'b0);
      drain(11'd4, 11'h100, 1'b1, 1);

      // No activations: weights only, done right after the flush; stray ofifo_valid ignored.
      ofifo_valid = 1'b1;
      front(11'h040, 11'h050, 11'd0, 11'h060, 1'b0, 1'b1, 0, 1'b0);
      ofifo_valid = 1'b0;
      step();
      chk("n0_done", IDLE_W, 1'b0, 1'b1);
      step();
      chk("n0_idle", IDLE_W, 1'b0, 1'b0);

      // Throttled drain with pmem address wrap.
      front(11'h000, 11'h010, 11'd3, 11'h7FE, 1'b1, 1'b0, 3, 1'b0);
      drain(11'd3, 11'h7FE, 1'b1, 3);

      // xmem address wrap on both fills, start pulsed during EXEC, ofifo_valid held high early.
      ofifo_valid = 1'b1;
      front(11'd2046, 11'd2047, 11'd2, 11'h020, 1'b0, 1'b1, 2, 1'b1);
      drain(11'd2, 11'h020, 1'b0, 2);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_after_poke", IDLE_W, 1'b0, 1'b0);
      end

      // Reset in the middle of EXEC: idle next cycle and no pmem write afterwards.
      front(11'h010, 11'h020, 11'd4, 11'h040, 1'b1, 1'b1, 2, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_mid_exec", IDLE_W, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         ofifo_valid = (i % 2 == 0);
         step();
         chk("post_reset", IDLE_W, 1'b0, 1'b0);
      end
      ofifo_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
